// File: rtl/aes_round_ctrl_if.sv
// Host and shared-round-hardware signal bundle for the iterative AES-128 sequencer.
// slave is the sequencer's view; master is the host/round-hardware environment's view.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         key_start;
  logic [127:0] key_in;
  logic [7:0]   key_rcon;
  logic         key_done;
  logic [127:0] key_out;
  logic         rnd_start;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         rnd_final;
  logic         rnd_done;
  logic [127:0] rnd_result;
  logic         busy;
  logic [3:0]   round_idx;
  logic         err;

  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    input  key_done, key_out, rnd_done, rnd_result,
    output in_ready, out_valid, out_text,
    output key_start, key_in, key_rcon,
    output rnd_start, rnd_state, rnd_key, rnd_final,
    output busy, round_idx, err
  );

  modport master (
    output in_valid, in_text, in_key, out_ready,
    output key_done, key_out, rnd_done, rnd_result,
    input  in_ready, out_valid, out_text,
    input  key_start, key_in, key_rcon,
    input  rnd_start, rnd_state, rnd_key, rnd_final,
    input  busy, round_idx, err
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: initial AddRoundKey, then 10 key/round exchanges with
// external key-expansion and round units, with a per-wait watchdog.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  aes_round_ctrl_if.slave bus
);

  localparam int DATA_W = 128;
  localparam int WD_W   = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, KEY, ROUND, OUT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   st_q, st_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   out_text_q, out_text_d;
  logic [3:0]          idx_q, idx_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [WD_W-1:0]     wd_q;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic                in_ready_q;
  logic                waiting;
  logic                first_cyc;
  logic                wd_expired;
  logic                last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // The watchdog count is zero exactly on the first cycle of each wait state.
  assign waiting    = (state_q == KEY) || (state_q == ROUND);
  assign first_cyc  = (wd_q == '0);
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
  assign last_round = (idx_q == 4'(NR));

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    key_d       = key_q;
    idx_d       = idx_q;
    rcon_d      = rcon_q;
    out_valid_d = out_valid_q;
    out_text_d  = out_text_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          st_d    = bus.in_text ^ bus.in_key;
          key_d   = bus.in_key;
          idx_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = KEY;
        end
      end
      KEY: begin
        if (bus.key_done) begin
          key_d   = bus.key_out;
          state_d = ROUND;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          idx_d   = 4'd0;
          state_d = IDLE;
        end
      end
      ROUND: begin
        if (bus.rnd_done) begin
          st_d = bus.rnd_result;
          if (last_round) begin
            out_text_d  = bus.rnd_result;
            out_valid_d = 1'b1;
            idx_d       = 4'd0;
            state_d     = OUT;
          end else begin
            idx_d   = idx_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            state_d = KEY;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          idx_d   = 4'd0;
          state_d = IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State boundary: every register, data included, clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      key_q       <= '0;
      out_text_q  <= '0;
      idx_q       <= '0;
      rcon_q      <= '0;
      wd_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      key_q       <= key_d;
      out_text_q  <= out_text_d;
      idx_q       <= idx_d;
      rcon_q      <= rcon_d;
      wd_q        <= ((state_d != state_q) || !waiting) ? '0 : wd_q + WD_W'(1);
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = out_text_q;
  assign bus.key_start = (state_q == KEY) && first_cyc;
  assign bus.key_in    = key_q;
  assign bus.key_rcon  = rcon_q;
  assign bus.rnd_start = (state_q == ROUND) && first_cyc;
  assign bus.rnd_state = st_q;
  assign bus.rnd_key   = key_q;
  assign bus.rnd_final = last_round;
  assign bus.busy      = waiting;
  assign bus.round_idx = idx_q;
  assign bus.err       = err_q;

endmodule
